// File: rtl/note_ctrl.sv
// rtl/note_ctrl.sv - monophonic note controller: note/velocity events to NCO phase increment, amplitude and gate
module note_ctrl (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ev_valid,
  output logic        o_ev_ready,
  input  logic        i_ev_on,
  input  logic [6:0]  i_ev_note,
  input  logic [6:0]  i_ev_vel,
  input  logic        i_all_off,
  output logic [23:0] o_f_out,
  output logic        o_load_f,
  output logic [15:0] o_a_out,
  output logic        o_load_a,
  output logic        o_key_on,
  output logic [6:0]  o_held_note
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DIV    = 3'd1,
    S_LOOKUP = 3'd2,
    S_SHIFT  = 3'd3,
    S_LOAD   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [6:0]  r_rem;
  logic [3:0]  r_oct;
  logic [6:0]  r_note;
  logic [6:0]  r_vel;
  logic [23:0] r_rom;

  logic        r_ev_ready;
  logic [23:0] r_f_out;
  logic [15:0] r_a_out;
  logic        r_load;
  logic        r_key_on;
  logic [6:0]  r_held_note;

  logic        w_accept;
  logic        w_rem_ge12;
  logic [3:0]  w_shamt;
  logic [23:0] w_shifted;
  logic        w_off_match;

  // Top-octave phase increments (MIDI notes 120..131) for 48 kHz and a 24-bit accumulator.
  function automatic logic [23:0] f_rom(input logic [3:0] idx);
    logic [23:0] v;
    case (idx)
      4'd0:    v = 24'd2926232;
      4'd1:    v = 24'd3100235;
      4'd2:    v = 24'd3284585;
      4'd3:    v = 24'd3479896;
      4'd4:    v = 24'd3686822;
      4'd5:    v = 24'd3906052;
      4'd6:    v = 24'd4138318;
      4'd7:    v = 24'd4384395;
      4'd8:    v = 24'd4645104;
      4'd9:    v = 24'd4921317;
      4'd10:   v = 24'd5213953;
      4'd11:   v = 24'd5523991;
      default: v = 24'd0;
    endcase
    return v;
  endfunction

  assign w_accept    = i_ev_valid & r_ev_ready & ~i_all_off;
  assign w_rem_ge12  = (r_rem >= 7'd12);
  assign w_shamt     = 4'd10 - r_oct;
  assign w_shifted   = r_rom >> w_shamt;
  assign w_off_match = r_key_on && (i_ev_note == r_held_note);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && i_ev_on) w_state_next = S_DIV;
      S_DIV:    if (!w_rem_ge12) w_state_next = S_LOOKUP;
      S_LOOKUP: w_state_next = S_SHIFT;
      S_SHIFT:  w_state_next = S_LOAD;
      S_LOAD:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (i_all_off) w_state_next = S_IDLE;
  end

  // Octave/semitone split by repeated subtraction, then ROM read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= 7'd0;
      r_oct  <= 4'd0;
      r_note <= 7'd0;
      r_vel  <= 7'd0;
      r_rom  <= 24'd0;
    end else begin
      if (r_state == S_IDLE && w_accept && i_ev_on) begin
        r_rem  <= i_ev_note;
        r_oct  <= 4'd0;
        r_note <= i_ev_note;
        r_vel  <= i_ev_vel;
      end
      if (r_state == S_DIV && w_rem_ge12) begin
        r_rem <= r_rem - 7'd12;
        r_oct <= r_oct + 4'd1;
      end
      if (r_state == S_LOOKUP) begin
        r_rom <= f_rom(r_rem[3:0]);
      end
    end
  end

  // Output registers; values loaded at the end of SHIFT are visible during LOAD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ev_ready  <= 1'b1;
      r_f_out     <= 24'd0;
      r_a_out     <= 16'd0;
      r_load      <= 1'b0;
      r_key_on    <= 1'b0;
      r_held_note <= 7'd0;
    end else begin
      r_ev_ready <= (w_state_next == S_IDLE) && !i_all_off;
      r_load     <= (r_state == S_SHIFT) && !i_all_off;
      if (i_all_off) begin
        r_key_on <= 1'b0;
      end else if (r_state == S_SHIFT) begin
        r_f_out     <= w_shifted;
        r_a_out     <= {1'b0, r_vel, 8'h00};
        r_key_on    <= 1'b1;
        r_held_note <= r_note;
      end else if (r_state == S_IDLE && w_accept && !i_ev_on && w_off_match) begin
        r_key_on <= 1'b0;
      end
    end
  end

  assign o_ev_ready  = r_ev_ready;
  assign o_f_out     = r_f_out;
  assign o_a_out     = r_a_out;
  assign o_load_f    = r_load;
  assign o_load_a    = r_load;
  assign o_key_on    = r_key_on;
  assign o_held_note = r_held_note;

endmodule

// File: tb/tb_note_ctrl.sv
// tb/tb_note_ctrl.sv - directed table-driven bench for note_ctrl
module tb_note_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic [6:0]  ev_vel;
  logic        all_off;
  logic [23:0] f_out;
  logic        load_f;
  logic [15:0] a_out;
  logic        load_a;
  logic        key_on;
  logic [6:0]  held_note;

  int n_checks = 0;
  int n_errors = 0;

  note_ctrl dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_ev_valid  (ev_valid),
    .o_ev_ready  (ev_ready),
    .i_ev_on     (ev_on),
    .i_ev_note   (ev_note),
    .i_ev_vel    (ev_vel),
    .i_all_off   (all_off),
    .o_f_out     (f_out),
    .o_load_f    (load_f),
    .o_a_out     (a_out),
    .o_load_a    (load_a),
    .o_key_on    (key_on),
    .o_held_note (held_note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  note;
    logic [6:0]  vel;
    int          lat;
    logic [23:0] f;
    logic [15:0] a;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic do_note_on(input logic [6:0] note, input logic [6:0] vel, input int exp_lat,
                            input logic [23:0] exp_f, input logic [15:0] exp_a);
    int pulses, first, la_mis, rdy_bad, key_bad;
    logic k0;
    logic [23:0] f_at;
    logic [15:0] a_at;
    logic key_at;
    logic [6:0] held_at;
    pulses = 0; first = 0; la_mis = 0; rdy_bad = 0; key_bad = 0;
    f_at = 0; a_at = 0; key_at = 0; held_at = 0;
    k0 = key_on;
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = note; ev_vel = vel;
    chk($sformatf("ready_before_on_%0d", note), {31'd0, ev_ready}, 32'd1);
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) ev_valid = 1'b0;
      if (load_f) begin
        pulses++;
        if (first == 0) first = k;
      end
      if (load_a !== load_f) la_mis++;
      if (k <= exp_lat && ev_ready) rdy_bad++;
      if (k == exp_lat + 1 && !ev_ready) rdy_bad++;
      if (k < exp_lat && key_on !== k0) key_bad++;
      if (k == exp_lat) begin
        f_at = f_out; a_at = a_out; key_at = key_on; held_at = held_note;
      end
    end
    chk($sformatf("latency_%0d", note), first, exp_lat);
    chk($sformatf("pulses_%0d", note), pulses, 1);
    chk($sformatf("loada_eq_loadf_%0d", note), la_mis, 0);
    chk($sformatf("ready_pattern_%0d", note), rdy_bad, 0);
    chk($sformatf("key_hold_%0d", note), key_bad, 0);
    chk($sformatf("f_out_%0d", note), {8'd0, f_at}, {8'd0, exp_f});
    chk($sformatf("a_out_%0d", note), {16'd0, a_at}, {16'd0, exp_a});
    chk($sformatf("key_on_%0d", note), {31'd0, key_at}, 32'd1);
    chk($sformatf("held_%0d", note), {25'd0, held_at}, {25'd0, note});
  endtask

  task automatic do_note_off(input logic [6:0] note, input logic exp_key, input logic [23:0] exp_f);
    ev_valid = 1'b1; ev_on = 1'b0; ev_note = note; ev_vel = 7'd0;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    chk($sformatf("off_key_%0d", note), {31'd0, key_on}, {31'd0, exp_key});
    chk($sformatf("off_ready_%0d", note), {31'd0, ev_ready}, 32'd1);
    chk($sformatf("off_noload_%0d", note), {31'd0, load_f}, 32'd0);
    chk($sformatf("off_f_%0d", note), {8'd0, f_out}, {8'd0, exp_f});
  endtask

  initial begin
    int pulses, rdy_bad, waited, first;
    vecs[0]  = '{7'd69,  7'd100, 9,  24'd153791,  16'h6400};
    vecs[1]  = '{7'd0,   7'd1,   4,  24'd2857,    16'h0100};
    vecs[2]  = '{7'd127, 7'd127, 14, 24'd4384395, 16'h7F00};
    vecs[3]  = '{7'd60,  7'd64,  9,  24'd91444,   16'h4000};
    vecs[4]  = '{7'd11,  7'd5,   4,  24'd5394,    16'h0500};
    vecs[5]  = '{7'd12,  7'd6,   5,  24'd5715,    16'h0600};
    vecs[6]  = '{7'd13,  7'd7,   5,  24'd6055,    16'h0700};
    vecs[7]  = '{7'd50,  7'd8,   8,  24'd51321,   16'h0800};
    vecs[8]  = '{7'd27,  7'd9,   6,  24'd13593,   16'h0900};
    vecs[9]  = '{7'd100, 7'd10,  12, 24'd921705,  16'h0A00};
    vecs[10] = '{7'd29,  7'd11,  6,  24'd15258,   16'h0B00};
    vecs[11] = '{7'd42,  7'd12,  7,  24'd32330,   16'h0C00};
    vecs[12] = '{7'd44,  7'd13,  7,  24'd36289,   16'h0D00};
    vecs[13] = '{7'd81,  7'd14,  10, 24'd307582,  16'h0E00};
    vecs[14] = '{7'd94,  7'd15,  11, 24'd651744,  16'h0F00};
    vecs[15] = '{7'd119, 7'd16,  13, 24'd2761995, 16'h1000};

    rst_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = 7'd0; ev_vel = 7'd0; all_off = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_f_out", {8'd0, f_out}, 32'd0);
    chk("rst_a_out", {16'd0, a_out}, 32'd0);
    chk("rst_key_on", {31'd0, key_on}, 32'd0);
    chk("rst_load_f", {31'd0, load_f}, 32'd0);
    chk("rst_load_a", {31'd0, load_a}, 32'd0);
    chk("rst_ready", {31'd0, ev_ready}, 32'd1);
    chk("rst_held", {25'd0, held_note}, 32'd0);

    // First entries: 69, then 0 followed by legato 127; the rest cover every ROM slot.
    for (int i = 0; i < 16; i++) begin
      do_note_on(vecs[i].note, vecs[i].vel, vecs[i].lat, vecs[i].f, vecs[i].a);
    end

    do_note_on(7'd69, 7'd100, 9, 24'd153791, 16'h6400);
    do_note_off(7'd60, 1'b1, 24'd153791);
    do_note_off(7'd69, 1'b0, 24'd153791);
    do_note_off(7'd69, 1'b0, 24'd153791);

    // all_off during a computation while another event is pending.
    do_note_on(7'd60, 7'd64, 9, 24'd91444, 16'h4000);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd69; ev_vel = 7'd100;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    all_off = 1'b1;
    pulses = 0; rdy_bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (load_f) pulses++;
      if (ev_ready) rdy_bad++;
    end
    chk("alloff_nopulse", pulses, 0);
    chk("alloff_ready_low", rdy_bad, 0);
    chk("alloff_key", {31'd0, key_on}, 32'd0);
    chk("alloff_f_hold", {8'd0, f_out}, 32'd91444);
    chk("alloff_a_hold", {16'd0, a_out}, 32'h4000);
    all_off = 1'b0;
    waited = 0;
    while (!ev_ready && waited < 10) begin
      @(negedge clk);
      if (load_f) pulses++;
      waited++;
    end
    chk("alloff_idle_nopulse", pulses, 0);
    chk("alloff_ready_return", {31'd0, ev_ready}, 32'd1);
    @(posedge clk);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) ev_valid = 1'b0;
      if (load_f && first == 0) begin
        first = k;
        chk("alloff_resume_f", {8'd0, f_out}, 32'd153791);
        chk("alloff_resume_held", {25'd0, held_note}, 32'd69);
      end
    end
    chk("alloff_resume_latency", first, 9);
    chk("alloff_resume_key", {31'd0, key_on}, 32'd1);

    // Reset in the DIV state of note 127.
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd127; ev_vel = 7'd127;
    @(posedge clk);
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_f", {8'd0, f_out}, 32'd0);
    chk("midrst_a", {16'd0, a_out}, 32'd0);
    chk("midrst_key", {31'd0, key_on}, 32'd0);
    chk("midrst_ready", {31'd0, ev_ready}, 32'd1);
    chk("midrst_held", {25'd0, held_note}, 32'd0);
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (load_f) pulses++;
    end
    chk("midrst_nopulse", pulses, 0);
    rst_n = 1'b1;
    do_note_on(7'd69, 7'd100, 9, 24'd153791, 16'h6400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/note_ctrl.md
# note_ctrl

Monophonic note controller directly upstream of the NCO voice. It accepts note-on/note-off events over a valid/ready handshake and converts the 7-bit note number into a 24-bit phase increment using a 12-entry top-octave ROM and a right shift. It also converts velocity into a 16-bit amplitude. It then drives the NCO's frequency load, amplitude load and key_on inputs.

## Interface
- No parameters. The table is fixed for a 48 kHz sample clock and a 24-bit phase accumulator.
- Clk  in  1  sample-rate clock; the same clock as the NCO.
- Reset  in  1  asynchronous, active-low reset.
- ev_valid  in  1  event present; must be held until accepted.
- ev_ready  out  1  controller can accept an event.
- ev_on  in  1  1 = note-on, 0 = note-off.
- ev_note  in  7  MIDI note number, 0..127.
- ev_vel  in  7  velocity; ignored for note-off.
- all_off  in  1  synchronous panic.
- F_out  out  24  phase increment; connects to the NCO F_in.
- loadF  out  1  one-cycle load strobe for F_out.
- A_out  out  16  amplitude; connects to the NCO A_in.
- loadA  out  1  one-cycle load strobe for A_out. Always equal to loadF.
- key_on  out  1  gate to the NCO/ADSR.
- held_note  out  7  note currently sounding. Valid while key_on = 1.

## Operation
- All outputs are registered.
- Reset (Reset = 0) forces the following, regardless of Clk:
  - state IDLE;
  - ev_ready = 1;
  - F_out = 0, A_out = 0;
  - loadF = loadA = 0;
  - key_on = 0;
  - held_note = 0.
- An event is accepted on the rising edge where ev_valid & ev_ready & ~all_off. ev_note, ev_vel and ev_on are captured on that edge.
- States:
  - IDLE: ev_ready = 1.
    - On an accepted note-on, go to DIV with rem = note, oct = 0.
    - On an accepted note-off: if key_on = 1 and ev_note == held_note, clear key_on on that edge; otherwise ignore the event. Stay in IDLE.
  - DIV: one subtraction per cycle. If rem ≥ 12, then rem −= 12 and oct += 1. Otherwise go to LOOKUP. DIV lasts oct+1 cycles; oct ends in 0..10 and rem in 0..11.
  - LOOKUP: registered ROM read of entry rem. Entry s = round(2^24 · 440 · 2^((120+s−69)/12) / 48000):
    - 0: 2926232
    - 7: 4384395
    - 9: 4921317
    - remaining entries follow the formula.
  - SHIFT: result = rom >> (10 − oct), a logical shift that truncates. Register the result into F_out. Register A_out = {1'b0, vel, 8'h00}.
  - LOAD: loadF = loadA = 1 for this cycle only. key_on = 1 and held_note = note, asserted in this same cycle. Then go to IDLE.
- ev_ready = 0 in DIV, LOOKUP, SHIFT and LOAD. Events arriving during these states wait under the handshake.
- A note-on while key_on = 1 (same or different note) is legato:
  - key_on stays 1 throughout;
  - F_out and A_out are reloaded in LOAD;
  - held_note is replaced.
- all_off = 1, in any state, on the next edge:
  - key_on = 0;
  - any in-flight computation is aborted with no loadF pulse;
  - state goes to IDLE.
  - ev_ready is forced to 0 while all_off = 1, so all_off always wins over a simultaneous event.
- F_out and A_out hold their last loaded values after note-off and all_off. Only reset clears them.

## Timing
- Note-on latency: measured from accepting edge E0, loadF is high during cycle oct+4 after E0.
  - Note 0 (oct 0): cycle 4.
  - Note 69 (oct 5): cycle 9.
  - Note 127 (oct 10): cycle 14.
- ev_ready returns to 1 in cycle oct+5. Maximum back-to-back note-on throughput is one per oct+5 cycles.
- Note-off (matching or ignored): key_on changes in cycle 1 after E0. ev_ready never drops, so a new event can be accepted on the very next edge.
- The NCO captures F_out and A_out on the edge that ends the LOAD cycle. F_out and A_out are stable from LOAD onward.
- Reset asserted mid-computation: outputs return to their reset values immediately, with no loadF pulse. The first event after reset release can be accepted on the first edge.

## Test plan
- Reset, then idle for 5 cycles -> F_out = 0, A_out = 0, key_on = 0, loadF = 0, ev_ready = 1.
- Note-on 69, vel 100 -> single loadF/loadA pulse in cycle 9 after accept; F_out = 153791, A_out = 0x6400, key_on = 1, held_note = 69; ev_ready low for cycles 1–9.
- Note-on 0, then note-on 127 (legato) -> first F_out = 2857 (loadF in cycle 4); then F_out = 4384395 (loadF in cycle 14 after the second accept); key_on never drops.
- Note-off 60 while 69 is held -> key_on stays 1. Then note-off 69 -> key_on = 0 in cycle 1; F_out is unchanged.
- all_off asserted in cycle 3 of a note-on 69 computation, with ev_valid also high -> no loadF pulse, key_on = 0, state IDLE, event not accepted until all_off = 0.
- Reset asserted during the DIV state of note 127 -> immediate return to reset values, no loadF pulse. After release, note-on 69 completes normally in 9 cycles.
